mem_wb_buf: RTL and testbench
=============================

# mem_wb_buf

Parametrised MEM→WB stage buffer for the RISC-V core. It replaces the single stall-gated MEM/WB register with a DEPTH-entry in-order queue and a valid/ready handshake on both sides, plus a flush input. It also provides a combinational forwarding port that returns the youngest buffered write to a queried register. It sits between the memory-access stage and the register-file write port.

## Interface
- DATA_W, 32, width of write-back data
- ADDR_W, 5, width of destination register address
- DEPTH, 2, queue entries; legal 2..8
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all buffered entries this cycle
- mem_valid  in  1  MEM stage presents a result
- mem_ready  out  1  buffer accepts a result this cycle
- mem_wd  in  ADDR_W  destination register
- mem_wreg  in  1  register write enable
- mem_wdata  in  DATA_W  write data
- wb_valid  out  1  head entry valid
- wb_ready  in  1  WB consumes head this cycle
- wb_wd  out  ADDR_W  head destination register
- wb_wreg  out  1  head write enable
- wb_wdata  out  DATA_W  head write data
- fwd_raddr  in  ADDR_W  forwarding query address
- fwd_hit  out  1  a buffered entry writes fwd_raddr
- fwd_data  out  DATA_W  data of youngest matching entry
- count  out  clog2(DEPTH+1)  occupied entries

## Operation
- Circular queue with read and write pointers, each of width clog2(DEPTH), wrapping at DEPTH-1→0. DEPTH need not be a power of two.
- push = mem_valid & mem_ready; pop = wb_valid & wb_ready.
- mem_ready = (count < DEPTH). It is registered-state-only; there is no combinational path from wb_ready.
- wb_valid = (count != 0).
- wb_wd/wb_wreg/wb_wdata show the head entry when wb_valid=1. When wb_valid=0 they read 0/0/0.
- Stored wreg = mem_wreg & (mem_wd != 0), so x0 is never written.
- Entries with wreg=0 still occupy a slot and are popped normally.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push when full cannot occur, because mem_ready is low.
- Pop when empty is ignored.
- flush=1: count, read pointer and write pointer all become 0 next cycle. Any push or pop in the same cycle is discarded.
- Forwarding:
  - fwd_hit=1 if any valid entry has wreg=1 and wd==fwd_raddr, with fwd_raddr≠0.
  - fwd_data comes from the youngest such entry (nearest to the write pointer).
  - fwd_data=0 when fwd_hit=0.
  - The forwarding logic is purely combinational over the current queue contents and does not include the entry being pushed this cycle.

## Timing
- Reset: count=0, pointers=0, wb_valid=0, wb_wd=0, wb_wreg=0, wb_wdata=0, mem_ready=1, fwd_hit=0, fwd_data=0. Queue storage is not required to be cleared.
- rst has priority over flush. flush has priority over push/pop.
- Latency: an entry pushed in cycle N is visible on wb_* in cycle N+1 if the queue was empty. Otherwise it appears after all older entries are popped.
- Throughput: 1 entry/cycle sustained when wb_ready is held at 1.
- mem_ready deasserts in the cycle after the push that fills the queue. It reasserts in the cycle after the first pop from full.
- Reset or flush mid-stream: all in-flight entries are lost. No wb_valid pulse follows.

## Test plan
- Reset then a single push: hold rst 1 cycle, push wd=5/wreg=1/data=0xDEADBEEF with wb_ready=0 → next cycle wb_valid=1, wb_wd=5, wb_wdata=0xDEADBEEF, count=1; after wb_ready=1 for one cycle → count=0 and wb_* read 0.
- Fill and backpressure, DEPTH=2: push A (wd=1), push B (wd=2) with wb_ready=0 → count=2, mem_ready=0; a third mem_valid is not accepted. Then pop → wb shows A then B in order, and mem_ready=1 the cycle after the first pop.
- Streaming with wrap: DEPTH=3, wb_ready=1, push 10 consecutive entries with data 1..10 → wb_wdata reads 1..10 on consecutive cycles, one cycle behind the pushes; count never exceeds 1.
- x0 suppression and forwarding: push wd=0/wreg=1, then wd=7/data=0x11, then wd=7/data=0x22, all stalled. Query 7 → fwd_hit=1, fwd_data=0x22. Query 0 → fwd_hit=0. Head entry shows wb_wreg=0.
- Flush with simultaneous traffic: with count=2, assert flush together with mem_valid=1 and wb_ready=1 → next cycle count=0, wb_valid=0, fwd_hit=0 for every address.
- Reset mid-stream: with a full queue, assert rst while pushing → next cycle all outputs at their reset values and mem_ready=1.

Source files
------------

// File: rtl/mem_wb_buf.sv
// mem_wb_buf: MEM->WB stage buffer built as a DEPTH-entry in-order circular queue.
// It has a valid/ready handshake on both sides, a flush input, and a combinational
// forwarding port that returns the youngest buffered write to a queried register.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             drop every buffered entry at the next edge
//   mem_valid/ready   producer handshake; mem_ready depends only on registered occupancy
//   mem_wd/wreg/wdata result presented by the MEM stage
//   wb_valid/ready    consumer handshake on the head entry
//   wb_wd/wreg/wdata  head entry fields; all zero while the queue is empty
//   fwd_raddr         forwarding query register address
//   fwd_hit/fwd_data  youngest buffered write to fwd_raddr; data is zero on a miss
//   count             number of occupied entries
module mem_wb_buf #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic [ADDR_W-1:0]          mem_wd,
   input  logic                       mem_wreg,
   input  logic [DATA_W-1:0]          mem_wdata,
   output logic                       wb_valid,
   input  logic                       wb_ready,
   output logic [ADDR_W-1:0]          wb_wd,
   output logic                       wb_wreg,
   output logic [DATA_W-1:0]          wb_wdata,
   input  logic [ADDR_W-1:0]          fwd_raddr,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] wd_mem   [DEPTH];
   logic              wreg_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic push, pop;

   // Pointers wrap explicitly since DEPTH need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      if (ptr == PtrW'(DEPTH - 1)) begin
         return '0;
      end
      return ptr + PtrW'(1);
   endfunction

   assign mem_ready = (count_q < CntW'(DEPTH));
   assign wb_valid  = (count_q != '0);
   assign push      = mem_valid & mem_ready;
   assign pop       = wb_valid & wb_ready;
   assign count     = count_q;

   assign wb_wd    = wb_valid ? wd_mem[rd_ptr_q]   : '0;
   assign wb_wreg  = wb_valid ? wreg_mem[rd_ptr_q] : 1'b0;
   assign wb_wdata = wb_valid ? data_mem[rd_ptr_q] : '0;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push && !pop) begin
            count_d = count_q + CntW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left uninitialised; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push) begin
         wd_mem[wr_ptr_q]   <= mem_wd;
         wreg_mem[wr_ptr_q] <= mem_wreg & (mem_wd != '0);
         data_mem[wr_ptr_q] <= mem_wdata;
      end
   end

   // Walk entries oldest to youngest so the last match found is the youngest.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         int unsigned     pos;
         logic [PtrW-1:0] idx;
         pos = 32'(rd_ptr_q) + i;
         if (pos >= DEPTH) begin
            pos = pos - DEPTH;
         end
         idx = PtrW'(pos);
         if ((i < 32'(count_q)) && wreg_mem[idx] && (wd_mem[idx] == fwd_raddr) &&
             (fwd_raddr != '0)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_mem[idx];
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_buf.sv
module tb_mem_wb_buf;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 3;
   localparam int unsigned CNT_W  = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst, flush, mem_valid, mem_wreg, wb_ready;
   logic              mem_ready, wb_valid, wb_wreg, fwd_hit;
   logic [ADDR_W-1:0] mem_wd, wb_wd, fwd_raddr;
   logic [DATA_W-1:0] mem_wdata, wb_wdata, fwd_data;
   logic [CNT_W-1:0]  count;

   typedef struct packed {
      logic [ADDR_W-1:0] wd;
      logic              wreg;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t mq[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mem_wb_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wd(mem_wd),
      .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wd(wb_wd),
      .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs straight from the queue contents.
   task automatic check_model();
      logic              hit = 1'b0;
      logic [DATA_W-1:0] fd  = '0;
      ent_t              head = '0;
      if (mq.size() != 0) head = mq[0];
      if (fwd_raddr != '0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].wreg && (mq[i].wd == fwd_raddr)) begin
               hit = 1'b1;
               fd  = mq[i].data;
               break;
            end
         end
      end
      chk("count", 64'(count), 64'(mq.size()));
      chk("mem_ready", 64'(mem_ready), 64'(mq.size() < int'(DEPTH)));
      chk("wb_valid", 64'(wb_valid), 64'(mq.size() != 0));
      chk("wb_wd", 64'(wb_wd), 64'(head.wd));
      chk("wb_wreg", 64'(wb_wreg), 64'(head.wreg));
      chk("wb_wdata", 64'(wb_wdata), 64'(head.data));
      chk("fwd_hit", 64'(fwd_hit), 64'(hit));
      chk("fwd_data", 64'(fwd_data), 64'(fd));
   endtask

   // Check before the edge, then advance the model with the held inputs.
   task automatic cycle();
      #1;
      check_model();
      @(posedge clk);
      if (rst || flush) begin
         mq.delete();
      end else begin
         bit   do_pop;
         bit   do_push;
         ent_t e;
         do_pop  = wb_ready && (mq.size() != 0);
         do_push = mem_valid && (mq.size() < int'(DEPTH));
         e.wd    = mem_wd;
         e.wreg  = mem_wreg && (mem_wd != '0);
         e.data  = mem_wdata;
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [ADDR_W-1:0] wd, input logic wr,
                        input logic [DATA_W-1:0] d, input logic rdy);
      mem_valid = v;
      mem_wd    = wd;
      mem_wreg  = wr;
      mem_wdata = d;
      wb_ready  = rdy;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; fwd_raddr = '0;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mq.delete();

      // Reset state
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_mem_ready", 64'(mem_ready), 64'd1);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      cycle();

      // Single push, then pop
      drive(1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      #1;
      chk("single_wd", 64'(wb_wd), 64'd5);
      chk("single_wdata", 64'(wb_wdata), 64'hDEAD_BEEF);
      chk("single_count", 64'(count), 64'd1);
      cycle();
      wb_ready = 1'b1;
      cycle();
      wb_ready = 1'b0;
      #1;
      chk("single_drained", 64'(wb_wdata), 64'd0);
      cycle();

      // Fill, backpressure, ordered drain
      for (int i = 1; i <= int'(DEPTH); i++) begin
         drive(1'b1, ADDR_W'(i), 1'b1, DATA_W'(32'h100 + i), 1'b0);
         cycle();
      end
      drive(1'b1, 5'd9, 1'b1, 32'h999, 1'b0);
      #1;
      chk("full_mem_ready", 64'(mem_ready), 64'd0);
      cycle();
      chk("full_count", 64'(count), 64'(DEPTH));
      for (int i = 1; i <= int'(DEPTH); i++) begin
         drive(1'b0, '0, 1'b0, '0, 1'b1);
         #1;
         chk("drain_order", 64'(wb_wd), 64'(i));
         cycle();
         if (i == 1) chk("ready_after_pop", 64'(mem_ready), 64'd1);
      end
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      cycle();

      // Streaming with pointer wrap
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, ADDR_W'(i), 1'b1, DATA_W'(i), 1'b1);
         cycle();
         chk("stream_data", 64'(wb_wdata), 64'(i));
         chk("stream_count_le1", 64'(count <= CNT_W'(1)), 64'd1);
      end
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      cycle();

      // x0 suppression and youngest-match forwarding
      drive(1'b1, 5'd0, 1'b1, 32'h55, 1'b0);
      cycle();
      drive(1'b1, 5'd7, 1'b1, 32'h11, 1'b0);
      cycle();
      drive(1'b1, 5'd7, 1'b1, 32'h22, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      fwd_raddr = 5'd7;
      #1;
      chk("fwd7_hit", 64'(fwd_hit), 64'd1);
      chk("fwd7_data", 64'(fwd_data), 64'h22);
      chk("x0_wreg", 64'(wb_wreg), 64'd0);
      fwd_raddr = 5'd0;
      #1;
      chk("fwd0_hit", 64'(fwd_hit), 64'd0);
      cycle();

      // Flush with simultaneous push and pop at count=2
      wb_ready = 1'b1;
      cycle();
      chk("pre_flush_count", 64'(count), 64'd2);
      flush = 1'b1;
      drive(1'b1, 5'd3, 1'b1, 32'h33, 1'b1);
      cycle();
      flush = 1'b0;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      for (int a = 0; a < (1 << ADDR_W); a++) begin
         fwd_raddr = ADDR_W'(a);
         #1;
         chk("flush_fwd_hit", 64'(fwd_hit), 64'd0);
      end
      chk("flush_count", 64'(count), 64'd0);
      cycle();

      // Reset mid-stream while pushing into a full queue
      for (int i = 1; i <= int'(DEPTH); i++) begin
         drive(1'b1, ADDR_W'(i), 1'b1, DATA_W'(i * 3), 1'b0);
         cycle();
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      #1;
      chk("midrst_mem_ready", 64'(mem_ready), 64'd1);
      chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
      cycle();

      // Randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 6)),
               1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0));
         flush     = ($urandom_range(0, 39) == 0);
         rst       = ($urandom_range(0, 79) == 0);
         fwd_raddr = ADDR_W'($urandom_range(0, 6));
         cycle();
      end
      rst = 1'b0;
      flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
